// File: rtl/nios2_oci_dct_capture.sv
// Debug-trace capture FIFO: stores {count, payload} words while running, then
// drains on request and stops; reads stay available in every state.
module nios2_oci_dct_capture #(
    parameter int DCT_WIDTH = 30,
    parameter int CNT_WIDTH = 4,
    parameter int DEPTH     = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [DCT_WIDTH-1:0]           dct_buffer,
    input  logic [CNT_WIDTH-1:0]           dct_count,
    input  logic                           dct_valid,
    input  logic                           test_ending,
    input  logic                           test_has_ended,
    input  logic                           rd_en,
    output logic [DCT_WIDTH+CNT_WIDTH-1:0] rd_data,
    output logic                           rd_valid,
    output logic [$clog2(DEPTH):0]         level,
    output logic                           overflow,
    output logic [7:0]                     drop_count,
    output logic                           done
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int ENT_W = DCT_WIDTH + CNT_WIDTH;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               rd_valid_q, rd_valid_d;
    logic [ENT_W-1:0]   rd_data_q, rd_data_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_q, drop_d;
    logic [ENT_W-1:0]   mem [DEPTH];

    logic capture, pop, full, empty, wr, drop;

    always_comb begin
        full    = (level_q == LVL_W'(DEPTH));
        empty   = (level_q == '0);
        // The cycle that first sees a stop request already refuses captures.
        capture = (state_q == RUN) && dct_valid && (dct_count != '0)
                  && !test_ending && !test_has_ended;
        pop     = rd_en && !empty;
        wr      = capture && (!full || pop);
        drop    = capture && full && !pop;

        wr_ptr_d   = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q + LVL_W'(wr) - LVL_W'(pop);
        rd_valid_d = pop;
        rd_data_d  = pop ? mem[rd_ptr_q] : rd_data_q;
        overflow_d = overflow_q | drop;
        drop_d     = drop ? sat_inc8(drop_q) : drop_q;

        state_d = state_q;
        case (state_q)
            RUN: begin
                if (test_has_ended)   state_d = DONE;
                else if (test_ending) state_d = DRAIN;
            end
            DRAIN: begin
                if (test_has_ended || empty) state_d = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage is never cleared; a full-level write lands on the slot being read,
    // which still returns the old entry because the read samples before update.
    always_ff @(posedge clk) begin
        if (reset_n && wr) begin
            mem[wr_ptr_q] <= {dct_count, dct_buffer};
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Bench for nios2_oci_dct_capture: directed scenarios plus random traffic,
// checked by a queue-based reference model and a negedge scoreboard monitor.
module tb_nios2_oci_dct_capture;

    localparam int DW    = 30;
    localparam int CW    = 4;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int EW    = DW + CW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] dct_buffer = '0;
    logic [CW-1:0] dct_count = '0;
    logic          dct_valid = 1'b0;
    logic          test_ending = 1'b0;
    logic          test_has_ended = 1'b0;
    logic          rd_en = 1'b0;
    logic [EW-1:0] rd_data;
    logic          rd_valid;
    logic [LW-1:0] level;
    logic          overflow;
    logic [7:0]    drop_count;
    logic          done;

    always #5 clk = ~clk;

    nios2_oci_dct_capture #(.DCT_WIDTH(DW), .CNT_WIDTH(CW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
        .overflow(overflow), .drop_count(drop_count), .done(done)
    );

    // Reference model: FIFO contents as a queue, mode as 0=running 1=draining 2=finished.
    logic [EW-1:0] m_fifo[$];
    logic [EW-1:0] exp_q[$];
    int            m_mode = 0;
    bit            m_ovf = 1'b0;
    int            m_drops = 0;
    logic [EW-1:0] m_rd = '0;
    bit            mon_en = 1'b0;
    int            checks = 0;
    int            passed = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endfunction

    function automatic void model_edge();
        int  lvl;
        bit  pop, cap;
        lvl = m_fifo.size();
        if (!reset_n) begin
            m_fifo.delete();
            m_mode  = 0;
            m_ovf   = 1'b0;
            m_drops = 0;
            m_rd    = '0;
            return;
        end
        pop = rd_en && (lvl > 0);
        cap = (m_mode == 0) && dct_valid && (dct_count != 0) && !test_ending && !test_has_ended;
        if (pop) begin
            m_rd = m_fifo.pop_front();
            exp_q.push_back(m_rd);
        end
        if (cap) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back({dct_count, dct_buffer});
            else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
        if (m_mode == 0) begin
            if (test_has_ended) m_mode = 2;
            else if (test_ending) m_mode = 1;
        end else if (m_mode == 1) begin
            if (test_has_ended || lvl == 0) m_mode = 2;
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                chk("rd_valid", 64'(rd_valid), 64'd1);
                chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
            end else begin
                chk("rd_valid_idle", 64'(rd_valid), 64'd0);
                chk("rd_data_hold", 64'(rd_data), 64'(m_rd));
            end
            chk("level", 64'(level), 64'(m_fifo.size()));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("drop_count", 64'(drop_count), 64'(m_drops));
            chk("done", 64'(done), 64'(m_mode == 2));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        dct_valid = 1'b0; dct_count = '0; dct_buffer = '0;
        rd_en = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic cap(input logic [CW-1:0] c, input logic [DW-1:0] b, input bit rd);
        dct_valid = 1'b1; dct_count = c; dct_buffer = b; rd_en = rd;
        tick();
    endtask

    task automatic pops(input int n);
        idle();
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) tick();
        idle();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        reset_n = 1'b1;

        // Three single-slot entries out in order.
        for (int i = 1; i <= 3; i++) cap(CW'(1), DW'(i), 1'b0);
        pops(3);
        tick();

        // Overfill by two, then saturate the drop counter, then read back in order.
        for (int i = 0; i < 18; i++) cap(CW'(1 + i % 15), DW'(32'h100 + i), 1'b0);
        for (int i = 0; i < 260; i++) cap(CW'(3), DW'($urandom), 1'b0);
        pops(17);

        // Full with simultaneous capture and pop keeps level and wraps pointers.
        do_reset();
        for (int i = 0; i < 16; i++) cap(CW'(2), DW'(32'h200 + i), 1'b0);
        for (int i = 0; i < 4; i++) cap(CW'(5), DW'(32'h300 + i), 1'b1);
        pops(16);
        tick();

        // Zero-count requests vanish; capture with pop at empty only writes.
        for (int i = 0; i < 5; i++) cap(CW'(0), DW'($urandom), 1'b0);
        cap(CW'(7), DW'(32'h3ABCDEF), 1'b1);
        pops(2);

        // Drain: captures refused once stop is requested, finish after level reaches 0.
        do_reset();
        for (int i = 0; i < 4; i++) cap(CW'(4), DW'(32'h400 + i), 1'b0);
        test_ending = 1'b1; dct_valid = 1'b1; dct_count = CW'(1); dct_buffer = DW'(32'h4FF);
        tick(); tick();
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rd_en = 1'b0;
        tick(); tick();
        idle();
        tick();

        // Immediate end with data still poppable in the finished state, then reset.
        do_reset();
        for (int i = 0; i < 6; i++) cap(CW'(6), DW'(32'h600 + i), 1'b0);
        test_has_ended = 1'b1;
        tick();
        idle();
        cap(CW'(1), DW'(32'h6FF), 1'b0);
        pops(8);
        reset_n = 1'b0;
        cap(CW'(1), DW'(32'h700), 1'b0);
        reset_n = 1'b1;
        cap(CW'(1), DW'(32'h701), 1'b0);
        pops(2);

        // Random traffic episodes with occasional resets and stop requests.
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int i = 0; i < 400; i++) begin
                dct_valid      = ($urandom_range(0, 3) != 0);
                dct_count      = ($urandom_range(0, 7) == 0) ? CW'(0) : CW'($urandom);
                dct_buffer     = DW'($urandom);
                rd_en          = ($urandom_range(0, 99) < (ep * 20 + 20));
                test_ending    = (i > 300) && ($urandom_range(0, 30) == 0);
                test_has_ended = (i > 350) && ($urandom_range(0, 60) == 0);
                reset_n        = ($urandom_range(0, 199) != 0);
                tick();
            end
            reset_n = 1'b1;
            pops(DEPTH + 2);
        end

        idle();
        tick(); tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
